online_otf_converter: RTL and testbench

//  Downstream stage of the online divider. Consumes the divider's MSD-first

---
 rtl/online_otf_converter.sv | 179 +++++++++++++++++
 tb/tb_online_otf_converter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/online_otf_converter.sv
// Online quotient-digit to two's-complement converter (Q/QM on-the-fly method).
// It takes the MSD-first radix-2 signed-digit quotient stream from the online
// divider and builds an (N_DIGITS+1)-bit fraction without a carry-propagate
// adder. The first DELAY digits of each frame are discarded because the
// divider emits them during its online delay.
module online_otf_converter #(
  parameter int N_DIGITS   = 16,
  parameter int DELAY      = 3,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                enable,
  input  logic                start,
  input  logic [1:0]          q_value,
  output logic [N_DIGITS:0]   result,
  output logic                result_valid,
  output logic                busy
);

  localparam int W       = N_DIGITS + 1;
  localparam int CNT_MAX = (N_DIGITS > DELAY) ? N_DIGITS : DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Last counter value of the skip phase (unused when DELAY is 0).
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((DELAY > 0) ? (DELAY - 1) : 0);
  // Counter value while the final digit of the frame is absorbed.
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SKIP = 2'b01,
    CONV = 2'b10
  } state_t;

  // One on-the-fly conversion step. Q holds the value so far, QM holds Q
  // minus one LSB; both are shifted left and one of them is selected so a
  // negative digit never needs a borrow chain. 00 and 11 both mean zero.
  function automatic logic [2*W-1:0] otf_step(
    input logic [W-1:0] q,
    input logic [W-1:0] qm,
    input logic [1:0]   digit
  );
    logic [W-1:0] q_n;
    logic [W-1:0] qm_n;
    case (digit)
      2'b10: begin
        q_n  = {q[W-2:0], 1'b1};
        qm_n = {q[W-2:0], 1'b0};
      end
      2'b01: begin
        q_n  = {qm[W-2:0], 1'b1};
        qm_n = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_n  = {q[W-2:0], 1'b0};
        qm_n = {qm[W-2:0], 1'b1};
      end
    endcase
    return {q_n, qm_n};
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [W-1:0]       q_r;
  logic [W-1:0]       q_next_s;
  logic [W-1:0]       qm_r;
  logic [W-1:0]       qm_next_s;
  logic [2*W-1:0]     step_s;
  logic               auto_pend_r;
  logic               start_eff_s;
  logic               done_s;
  logic [W-1:0]       result_r;
  logic               valid_r;
  logic               busy_r;

  // A pending automatic start behaves exactly like an external start pulse.
  assign start_eff_s = start | auto_pend_r;
  assign step_s      = otf_step(q_r, qm_r, q_value);

  // Next-state, counter and Q/QM update; nothing moves while enable is low.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    q_next_s     = q_r;
    qm_next_s    = qm_r;
    done_s       = 1'b0;
    if (enable) begin
      if (start_eff_s) begin
        // Start wins in every state and silently drops any frame in flight.
        state_next_s = (DELAY == 0) ? CONV : SKIP;
        cnt_next_s   = {CNT_W{1'b0}};
        q_next_s     = {W{1'b0}};
        qm_next_s    = {W{1'b1}};
      end else begin
        case (state_r)
          IDLE: begin
            state_next_s = IDLE;
          end
          SKIP: begin
            if (cnt_r == SKIP_LAST) begin
              state_next_s = CONV;
              cnt_next_s   = {CNT_W{1'b0}};
            end else begin
              cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          CONV: begin
            q_next_s  = step_s[2*W-1:W];
            qm_next_s = step_s[W-1:0];
            if (cnt_r == CONV_LAST) begin
              state_next_s = IDLE;
              cnt_next_s   = {CNT_W{1'b0}};
              done_s       = 1'b1;
            end else begin
              cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_next_s = IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
          end
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame state, digit counter and the Q/QM conversion registers.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      q_r     <= {W{1'b0}};
      qm_r    <= {W{1'b1}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      q_r     <= q_next_s;
      qm_r    <= qm_next_s;
    end
  end

  // Automatic-start request, armed by reset and consumed by the first enabled cycle.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      auto_pend_r <= AUTO_START;
    end else if (enable) begin
      auto_pend_r <= 1'b0;
    end else begin
      auto_pend_r <= auto_pend_r;
    end
  end

  // Result capture, one-cycle valid pulse (independent of enable) and busy flag.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      result_r <= {W{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (done_s) begin
        result_r <= q_next_s;
      end else begin
        result_r <= result_r;
      end
      valid_r <= done_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  assign result       = result_r;
  assign result_valid = valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for online_otf_converter: a vector table of complete frames
// plus hand-written stall, restart, reset and auto-start sequences.
module tb_online_otf_converter;

  localparam int N = 4;
  localparam int D = 2;

  logic       clk;
  logic       asyn_reset;
  logic       enable;
  logic       start;
  logic [1:0] q_value;
  logic [N:0] result;
  logic       result_valid;
  logic       busy;

  logic       rst_a;
  logic       en_a;
  logic       start_a;
  logic [1:0] q_a;
  logic [N:0] result_a;
  logic       valid_a;
  logic       busy_a;

  int checks;
  int errors;

  online_otf_converter #(.N_DIGITS(N), .DELAY(D), .AUTO_START(1'b0)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable(enable), .start(start),
    .q_value(q_value), .result(result), .result_valid(result_valid), .busy(busy)
  );

  online_otf_converter #(.N_DIGITS(N), .DELAY(D), .AUTO_START(1'b1)) dut_auto (
    .clk(clk), .asyn_reset(rst_a), .enable(en_a), .start(start_a),
    .q_value(q_a), .result(result_a), .result_valid(valid_a), .busy(busy_a)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] junk;   // two skipped digits, first in [3:2]
    logic [7:0] digs;   // four digits, MSD in [7:6]
    logic [4:0] exp;    // expected two's-complement result
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame: start, D junk digits, N digits (optional stall before the
  // third digit), then expect the pulse on the next observation.
  task automatic run_frame(input string tag, input logic [3:0] junk, input logic [7:0] digs,
                           input logic [4:0] exp, input int stall_len, input logic post_en);
    int early;
    int idle_busy;
    early     = 0;
    idle_busy = 0;
    enable  = 1'b1;
    start   = 1'b1;
    q_value = 2'b10;
    tick();
    start = 1'b0;
    if (result_valid) early++;
    if (!busy) idle_busy++;
    for (int i = 0; i < D; i++) begin
      q_value = junk[3 - 2*i -: 2];
      tick();
      if (result_valid) early++;
      if (!busy) idle_busy++;
    end
    for (int i = 0; i < N; i++) begin
      if (i == 2 && stall_len > 0) begin
        enable = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          q_value = 2'b10;
          tick();
          if (result_valid) early++;
          if (!busy) idle_busy++;
        end
        enable = 1'b1;
      end
      q_value = digs[7 - 2*i -: 2];
      tick();
      if (i < N - 1) begin
        if (result_valid) early++;
        if (!busy) idle_busy++;
      end
    end
    check({tag, " early_pulse"}, early, 0);
    check({tag, " busy_in_frame"}, idle_busy, 0);
    check({tag, " valid_on_time"}, {31'd0, result_valid}, 32'd1);
    check({tag, " result"}, {27'd0, result}, {27'd0, exp});
    enable  = post_en;
    q_value = 2'b00;
    tick();
    check({tag, " pulse_one_cycle"}, {31'd0, result_valid}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " result_held"}, {27'd0, result}, {27'd0, exp});
    enable = 1'b1;
  endtask

  // Begin a frame and feed n_digs digits of it, checking no pulse appears.
  task automatic run_partial(input string tag, input int n_digs);
    int bad;
    bad     = 0;
    enable  = 1'b1;
    start   = 1'b1;
    q_value = 2'b00;
    tick();
    start = 1'b0;
    if (result_valid) bad++;
    for (int i = 0; i < D + n_digs; i++) begin
      q_value = 2'b01;
      tick();
      if (result_valid) bad++;
    end
    check({tag, " no_pulse_partial"}, bad, 0);
  endtask

  initial begin
    int bad;
    checks     = 0;
    errors     = 0;
    enable     = 1'b0;
    start      = 1'b0;
    q_value    = 2'b00;
    asyn_reset = 1'b0;
    rst_a      = 1'b0;
    en_a       = 1'b0;
    start_a    = 1'b0;
    q_a        = 2'b00;

    vecs[0] = '{junk: 4'b0000, digs: 8'b10_00_01_10, exp: 5'b00111};
    vecs[1] = '{junk: 4'b0000, digs: 8'b01_01_01_01, exp: 5'b10001};
    vecs[2] = '{junk: 4'b0000, digs: 8'b10_10_10_10, exp: 5'b01111};
    vecs[3] = '{junk: 4'b1010, digs: 8'b10_11_11_00, exp: 5'b01000};
    vecs[4] = '{junk: 4'b0101, digs: 8'b00_00_00_00, exp: 5'b00000};
    vecs[5] = '{junk: 4'b1001, digs: 8'b01_10_00_00, exp: 5'b11100};
    vecs[6] = '{junk: 4'b1111, digs: 8'b10_01_01_01, exp: 5'b00001};

    #1;
    asyn_reset = 1'b1;
    rst_a      = 1'b1;
    #2;
    check("reset result", {27'd0, result}, 32'd0);
    check("reset valid", {31'd0, result_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    tick();
    asyn_reset = 1'b0;

    // Enabled idle cycles without start must not begin a frame.
    enable = 1'b1;
    repeat (3) tick();
    check("idle no_autostart busy", {31'd0, busy}, 32'd0);

    // Table of complete frames.
    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].junk, vecs[v].digs, vecs[v].exp, 0, 1'b1);
    end

    // Stall of 3 cycles mid-conversion; pulse still drops with enable low.
    run_frame("stall", 4'b1010, 8'b10_00_01_10, 5'b00111, 3, 1'b0);

    // Restart during CONV: old result held, aborted frame gives no pulse.
    run_frame("pre_restart", 4'b0000, 8'b10_10_10_10, 5'b01111, 0, 1'b1);
    run_partial("restart", 2);
    check("restart old_result_held", {27'd0, result}, 32'h0000000f);
    run_frame("restart_new", 4'b0000, 8'b10_00_01_10, 5'b00111, 0, 1'b1);

    // Start coincident with the last digit aborts that frame.
    run_partial("last_digit_abort", 3);
    check("last_digit_abort old_result", {27'd0, result}, 32'h00000007);
    run_frame("after_abort", 4'b0000, 8'b01_01_01_01, 5'b10001, 0, 1'b1);

    // Asynchronous reset mid-frame clears outputs immediately.
    run_partial("reset_mid", 2);
    #2;
    asyn_reset = 1'b1;
    #1;
    check("async_reset result", {27'd0, result}, 32'd0);
    check("async_reset busy", {31'd0, busy}, 32'd0);
    tick();
    asyn_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      q_value = 2'b10;
      tick();
      if (result_valid || busy) bad++;
    end
    check("after_reset no_pulse", bad, 0);

    // Auto-start instance: frame begins on the first enabled cycle.
    en_a = 1'b1;
    q_a  = 2'b00;
    tick();
    rst_a = 1'b0;
    bad = 0;
    begin
      logic [11:0] stream;
      stream = {2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
      for (int i = 0; i < D + N; i++) begin
        q_a = stream[11 - 2*i -: 2];
        tick();
        if (valid_a) bad++;
        if (!busy_a) bad++;
      end
      q_a = 2'b10;
      tick();
    end
    check("auto no_early_pulse", bad, 0);
    check("auto valid_on_time", {31'd0, valid_a}, 32'd1);
    check("auto result", {27'd0, result_a}, 32'h00000007);
    check("auto idle_after", {31'd0, busy_a}, 32'd0);
    tick();
    check("auto no_second_start", {31'd0, busy_a | valid_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
